// File: rtl/step_input_ctrl_if.sv
// step_input_ctrl_if
//   Bundles the pushbutton inputs and command-pulse outputs of the step
//   sequencer front end.
//
//   Signal semantics: there is no valid/ready handshake on this bus. The
//   btn_* lines are raw, asynchronous and may bounce. Each go_left / go_right
//   / srst assertion is a one-cycle command that the consumer must accept
//   in the cycle it is high. There is no backpressure.
//
//   Signals:
//     btn_left, btn_right, btn_clear : raw buttons (master -> slave)
//     go_left, go_right, srst        : one-cycle pulses (slave -> master)
//
//   Modports:
//     master : the button/sequencer side (drives buttons, sees pulses)
//     slave  : the step_input_ctrl block
interface step_input_ctrl_if;
  logic btn_left;
  logic btn_right;
  logic btn_clear;
  logic go_left;
  logic go_right;
  logic srst;

  modport master (
    output btn_left,
    output btn_right,
    output btn_clear,
    input  go_left,
    input  go_right,
    input  srst
  );

  modport slave (
    input  btn_left,
    input  btn_right,
    input  btn_clear,
    output go_left,
    output go_right,
    output srst
  );
endinterface

// File: rtl/step_input_ctrl.sv
// step_input_ctrl
//   Pushbutton front end for the step sequencer. Each raw button goes through
//   a 2-flop synchronizer and a counter debouncer. The debounced clear button
//   produces one srst pulse per press. The debounced direction buttons drive a
//   shared FSM that pulses go_left / go_right once on press, then auto-repeats
//   while the button is held. It locks out all direction pulses whenever both
//   directions are pressed, or a direction is pressed together with clear.
//
//   Parameters:
//     DEBOUNCE_CYCLES : cycles of disagreement needed to flip a debounced level (>= 1)
//     REPEAT_DELAY    : cycles from the first pulse to the first repeat (0 = no repeat)
//     REPEAT_PERIOD   : cycles between later repeats (>= 1)
//
//   Ports:
//     clk       : system clock, rising edge
//     rst       : asynchronous active-low reset
//     bus       : step_input_ctrl_if.slave (raw buttons in, command pulses out)
//     state_dbg : FSM state (0 IDLE, 1 HOLD_DELAY, 2 HOLD_REPEAT, 3 LOCKED)
module step_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 32,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic              clk,
  input  logic              rst,
  step_input_ctrl_if.slave  bus,
  output logic [1:0]        state_dbg
);

  // A counter of $clog2(N) bits reaches N-1. Clamp to 1 bit so that
  // parameter values of 0 or 1 still give a legal vector.
  localparam int CW_RAW = $clog2(DEBOUNCE_CYCLES);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam int TD_RAW = $clog2(REPEAT_DELAY);
  localparam int TP_RAW = $clog2(REPEAT_PERIOD);
  localparam int TW_MAX = (TD_RAW > TP_RAW) ? TD_RAW : TP_RAW;
  localparam int TW     = (TW_MAX < 1) ? 1 : TW_MAX;

  localparam logic [CW-1:0] DB_LAST     = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DELAY_LAST  = TW'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);
  localparam logic [TW-1:0] TIMER_MAX   = '1;

  localparam int B_LEFT  = 0;
  localparam int B_RIGHT = 1;
  localparam int B_CLEAR = 2;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    HOLD_DELAY  = 2'd1,
    HOLD_REPEAT = 2'd2,
    LOCKED      = 2'd3
  } state_t;

  logic [2:0]    raw;
  logic [2:0]    sync_a;
  logic [2:0]    sync_b;
  logic [2:0]    db;
  logic [CW-1:0] cnt [3];
  logic          db_clear_q;
  logic          srst_q;

  state_t        state;
  logic          dir;        // 0 = left, 1 = right
  logic [TW-1:0] timer;
  logic          go_left_q;
  logic          go_right_q;

  logic db_left;
  logic db_right;
  logic db_clear;
  logic db_dir;
  logic db_opp;

  assign raw = {bus.btn_clear, bus.btn_right, bus.btn_left};

  assign db_left  = db[B_LEFT];
  assign db_right = db[B_RIGHT];
  assign db_clear = db[B_CLEAR];

  // Level of the latched direction and of the other direction.
  assign db_dir = dir ? db_right : db_left;
  assign db_opp = dir ? db_left  : db_right;

  // Synchronizers and debouncers, one lane per button.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a <= '0;
      sync_b <= '0;
      db     <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      for (int i = 0; i < 3; i++) begin
        if (sync_b[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          db[i]  <= sync_b[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Clear: rising edge of the debounced level. It does not depend on the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_clear_q <= 1'b0;
      srst_q     <= 1'b0;
    end else begin
      db_clear_q <= db_clear;
      srst_q     <= db_clear & ~db_clear_q;
    end
  end

  // Direction FSM. Within each hold state the branch order makes release win
  // over lock, and lock win over timer expiry. A release in the same cycle as
  // an expiry therefore produces no pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      dir        <= 1'b0;
      timer      <= '0;
      go_left_q  <= 1'b0;
      go_right_q <= 1'b0;
    end else begin
      go_left_q  <= 1'b0;
      go_right_q <= 1'b0;
      case (state)
        IDLE: begin
          if ((db_left ^ db_right) && !db_clear) begin
            dir        <= db_right;
            go_left_q  <= db_left;
            go_right_q <= db_right;
            timer      <= '0;
            state      <= HOLD_DELAY;
          end else if (db_left || db_right) begin
            state <= LOCKED;
          end
        end
        HOLD_DELAY: begin
          if (!db_dir) begin
            state <= IDLE;
          end else if (db_opp || db_clear) begin
            state <= LOCKED;
          end else if ((REPEAT_DELAY != 0) && (timer == DELAY_LAST)) begin
            go_left_q  <= ~dir;
            go_right_q <= dir;
            timer      <= '0;
            state      <= HOLD_REPEAT;
          end else if (timer != TIMER_MAX) begin
            // With repeat disabled the timer just parks at its maximum.
            timer <= timer + TW'(1);
          end
        end
        HOLD_REPEAT: begin
          if (!db_dir) begin
            state <= IDLE;
          end else if (db_opp || db_clear) begin
            state <= LOCKED;
          end else if (timer == PERIOD_LAST) begin
            go_left_q  <= ~dir;
            go_right_q <= dir;
            timer      <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        LOCKED: begin
          if (!(db_left || db_right || db_clear)) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.go_left  = go_left_q;
  assign bus.go_right = go_right_q;
  assign bus.srst     = srst_q;
  assign state_dbg    = state;

endmodule

// File: tb/tb_step_input_ctrl.sv
// tb_step_input_ctrl
//   Drives two instances of step_input_ctrl with the same buttons: dut uses
//   REPEAT_DELAY=6, and dut_nr has repeat disabled. Both use DEBOUNCE_CYCLES=4
//   and REPEAT_PERIOD=3. A reference model predicts every cycle's outputs and
//   FSM state. It works from edge timestamps, so a pulse is due when a hold
//   has lasted 0, RD, RD+RP, RD+2RP ... edges. Directed scenarios come first,
//   then random button patterns.
module tb_step_input_ctrl;
  localparam int DB = 4;
  localparam int RD = 6;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] st;
  logic [1:0] st_nr;

  int checks = 0;
  int errors = 0;

  step_input_ctrl_if bus ();
  step_input_ctrl_if bus_nr ();

  assign bus_nr.btn_left  = bus.btn_left;
  assign bus_nr.btn_right = bus.btn_right;
  assign bus_nr.btn_clear = bus.btn_clear;

  step_input_ctrl #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg(st)
  );

  step_input_ctrl #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(0), .REPEAT_PERIOD(RP)) dut_nr (
    .clk(clk), .rst(rst), .bus(bus_nr), .state_dbg(st_nr)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_HOLD, M_LOCKED} mmode_t;

  logic [2:0] m_d1  [2];
  logic [2:0] m_d2  [2];
  logic [2:0] m_db  [2];
  int         m_run [2][3];
  logic       m_cq  [2];
  mmode_t     m_mode[2];
  logic       m_dir [2];
  int         m_start[2];
  int         m_n   [2];

  // Each entry is {nr: state,srst,go_r,go_l , main: state,srst,go_r,go_l}.
  logic [9:0] exp_q[$];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_d1[i] = '0; m_d2[i] = '0; m_db[i] = '0; m_cq[i] = 1'b0;
      m_mode[i] = M_IDLE; m_dir[i] = 1'b0; m_start[i] = 0; m_n[i] = 0;
      for (int b = 0; b < 3; b++) m_run[i][b] = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_step(input int i, input logic [2:0] raw, output logic [4:0] e);
    int rd, n, k;
    logic l, r, c, gl, gr, sr, on_dir, on_opp;
    logic [1:0] sc;
    rd = (i == 0) ? RD : 0;
    l = m_db[i][0]; r = m_db[i][1]; c = m_db[i][2];
    gl = 1'b0; gr = 1'b0;
    m_n[i] = m_n[i] + 1;
    n = m_n[i];
    sr = c & ~m_cq[i];
    m_cq[i] = c;
    on_dir = m_dir[i] ? r : l;
    on_opp = m_dir[i] ? l : r;
    case (m_mode[i])
      M_IDLE: begin
        if ((l ^ r) && !c) begin
          m_dir[i] = r; m_start[i] = n; m_mode[i] = M_HOLD; gl = l; gr = r;
        end else if (l | r) begin
          m_mode[i] = M_LOCKED;
        end
      end
      M_HOLD: begin
        if (!on_dir) m_mode[i] = M_IDLE;
        else if (on_opp || c) m_mode[i] = M_LOCKED;
        else begin
          k = n - m_start[i];
          if (rd > 0 && k >= rd && ((k - rd) % RP) == 0) begin
            gl = !m_dir[i]; gr = m_dir[i];
          end
        end
      end
      default: if (!(l | r | c)) m_mode[i] = M_IDLE;
    endcase
    if (m_mode[i] == M_IDLE) sc = 2'd0;
    else if (m_mode[i] == M_LOCKED) sc = 2'd3;
    else sc = (rd > 0 && (n - m_start[i]) >= rd) ? 2'd2 : 2'd1;
    // Debounced levels: flip after DB consecutive disagreeing samples.
    for (int b = 0; b < 3; b++) begin
      if (m_d2[i][b] == m_db[i][b]) m_run[i][b] = 0;
      else if (m_run[i][b] == DB - 1) begin
        m_db[i][b] = m_d2[i][b]; m_run[i][b] = 0;
      end else m_run[i][b] = m_run[i][b] + 1;
    end
    m_d2[i] = m_d1[i];
    m_d1[i] = raw;
    e = {sc, sr, gr, gl};
  endtask

  always @(posedge clk or negedge rst) begin
    logic [4:0] e0, e1;
    if (!rst) begin
      model_reset();
    end else begin
      model_step(0, {bus.btn_clear, bus.btn_right, bus.btn_left}, e0);
      model_step(1, {bus.btn_clear, bus.btn_right, bus.btn_left}, e1);
      exp_q.push_back({e1, e0});
    end
  end

  // ---------------- scoreboard (samples on falling edge) ----------------
  int pl[2], pr[2], ps[2];

  always @(negedge clk) begin
    logic [9:0] e;
    check("no_overlap", 8'(bus.go_left & bus.go_right), 8'd0);
    if (!rst) begin
      check("rst_go_left",  8'(bus.go_left),  8'd0);
      check("rst_go_right", 8'(bus.go_right), 8'd0);
      check("rst_srst",     8'(bus.srst),     8'd0);
      check("rst_state",    8'(st),           8'd0);
      check("rst_state_nr", 8'(st_nr),        8'd0);
    end else begin
      check("sb_depth", 8'(exp_q.size()), 8'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("go_left",     8'(bus.go_left),     8'(e[0]));
        check("go_right",    8'(bus.go_right),    8'(e[1]));
        check("srst",        8'(bus.srst),        8'(e[2]));
        check("state",       8'(st),              8'(e[4:3]));
        check("nr_go_left",  8'(bus_nr.go_left),  8'(e[5]));
        check("nr_go_right", 8'(bus_nr.go_right), 8'(e[6]));
        check("nr_srst",     8'(bus_nr.srst),     8'(e[7]));
        check("nr_state",    8'(st_nr),           8'(e[9:8]));
      end
    end
    pl[0] += int'(bus.go_left);    pr[0] += int'(bus.go_right);    ps[0] += int'(bus.srst);
    pl[1] += int'(bus_nr.go_left); pr[1] += int'(bus_nr.go_right); ps[1] += int'(bus_nr.srst);
  end

  // ---------------- driver tasks ----------------
  task automatic hold(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 2; i++) begin
      pl[i] = 0; pr[i] = 0; ps[i] = 0;
    end
  endtask

  task automatic check_counts(input string tag, input int l0, input int l1,
                              input int r0, input int r1, input int s);
    check({tag, "_left"},     8'(pl[0]), 8'(l0));
    check({tag, "_left_nr"},  8'(pl[1]), 8'(l1));
    check({tag, "_right"},    8'(pr[0]), 8'(r0));
    check({tag, "_right_nr"}, 8'(pr[1]), 8'(r1));
    check({tag, "_srst"},     8'(ps[0]), 8'(s));
    check({tag, "_srst_nr"},  8'(ps[1]), 8'(s));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] pat;
    int dur;
    bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_clear = 1'b0;
    clr_counts();
    rst = 1'b0;
    hold(3);
    rst = 1'b1;

    // Hold left for edges 1..15, then release.
    clr_counts();
    bus.btn_left = 1'b1;
    hold(15);
    bus.btn_left = 1'b0;
    hold(20);
    check_counts("s1", 4, 1, 0, 0, 0);
    check("s1_idle", 8'(st), 8'd0);

    // Short right glitch.
    clr_counts();
    bus.btn_right = 1'b1;
    hold(3);
    bus.btn_right = 1'b0;
    hold(10);
    check_counts("s2", 0, 0, 0, 0, 0);

    // Left held, right joins at edge 9, then releases one at a time.
    clr_counts();
    bus.btn_left = 1'b1;
    hold(8);
    bus.btn_right = 1'b1;
    hold(22);
    bus.btn_right = 1'b0;
    hold(15);
    check("s3_locked",    8'(st),    8'd3);
    check("s3_locked_nr", 8'(st_nr), 8'd3);
    bus.btn_left = 1'b0;
    hold(15);
    check("s3_idle", 8'(st), 8'd0);
    check_counts("s3", 2, 1, 0, 0, 0);
    clr_counts();
    bus.btn_right = 1'b1;
    hold(5);
    bus.btn_right = 1'b0;
    hold(15);
    check_counts("s3b", 0, 0, 1, 1, 0);

    // Clear pressed while left is repeating.
    clr_counts();
    bus.btn_left = 1'b1;
    hold(14);
    bus.btn_clear = 1'b1;
    hold(12);
    bus.btn_left = 1'b0;
    bus.btn_clear = 1'b0;
    hold(15);
    check_counts("s4", 4, 1, 0, 0, 1);

    // Reset right after a repeat pulse, with left still held.
    clr_counts();
    bus.btn_left = 1'b1;
    hold(15);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_go_left", 8'(bus.go_left), 8'd0);
    check("async_state",   8'(st),          8'd0);
    hold(1);
    rst = 1'b1;
    clr_counts();
    hold(10);
    check_counts("s5", 1, 1, 0, 0, 0);
    bus.btn_left = 1'b0;
    hold(15);

    // Random button patterns, including sub-debounce glitches.
    repeat (80) begin
      pat = 3'($urandom_range(0, 7));
      dur = $urandom_range(1, 30);
      bus.btn_left  = pat[0];
      bus.btn_right = pat[1];
      bus.btn_clear = pat[2];
      hold(dur);
    end
    bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_clear = 1'b0;
    hold(20);
    check("end_idle",    8'(st),    8'd0);
    check("end_idle_nr", 8'(st_nr), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
